// File: rtl/spi_regfile_param.sv
// SPI mode-0 slave register file: frames of {R/W, address, data} sampled on clk write a NUM_REGS x DATA_W bank.
// Define SPI_READBACK_EN to serve read frames on cipo; otherwise cipo/cipo_oe are tied low.
module spi_regfile_param #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync, fill;
  logic                   sclk_d, ncs_d;

  // ncs idles high so a reset never fabricates a chip-select edge; fill marks when the chain holds real pin samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      fill      <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, copi_s, sclk_rise, ncs_rise, ncs_fall;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic [FRAME_W-1:0] shift_q, shift_nxt;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic               armed_q;

  logic              addr_done, frame_done, frame_rw, addr_ok;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;

  assign shift_nxt  = {shift_q[FRAME_W-2:0], copi_s};
  assign cnt_inc    = (cnt_q == FRAME_END) ? cnt_q : cnt_q + CNT_W'(1);
  assign addr_done  = (state_q == ADDR) && sclk_rise && !ncs_rise && (cnt_inc == ADDR_END);
  assign frame_done = (state_q == DATA) && sclk_rise && !ncs_rise && (cnt_inc == FRAME_END);
  assign frame_rw   = shift_nxt[FRAME_W-1];
  assign frame_addr = shift_nxt[DATA_W +: ADDR_W];
  assign frame_data = shift_nxt[DATA_W-1:0];
  assign addr_ok    = 32'(frame_addr) < 32'(NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the bank is architecturally visible, so every entry is reset, not just the control state.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      // Frames only start after nCS has genuinely been seen high since reset.
      if (fill[SYNC_STAGES-1] && ncs_s) armed_q <= 1'b1;
      if (ncs_rise) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (ncs_fall && armed_q) begin
            state_q <= ADDR;
            cnt_q   <= '0;
          end
          ADDR, DATA: if (sclk_rise) begin
            shift_q <= shift_nxt;
            cnt_q   <= cnt_inc;
            if (addr_done) state_q <= DATA;
            if (frame_done) begin
              state_q <= DONE;
              if (frame_rw && addr_ok) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (frame_addr == ADDR_W'(i)) regs_q[i] <= frame_data;
                wr_strobe <= 1'b1;
                wr_addr   <= frame_addr;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_val, so_q, so_nxt;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign so_nxt    = so_q << 1;

  always_comb begin
    // NOTE: default first so no path through this block leaves rd_val holding its old value (no latch).
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
  end

  // MSB is presented right after the address; shifting starts on the fall following the first data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      so_q    <= '0;
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else if (ncs_rise || frame_done) begin
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else if (addr_done && !shift_nxt[ADDR_W]) begin
      so_q    <= rd_val;
      cipo    <= rd_val[DATA_W-1];
      cipo_oe <= 1'b1;
    end else if (cipo_oe && sclk_fall && cnt_q > ADDR_END) begin
      so_q <= so_nxt;
      cipo <= so_nxt[DATA_W-1];
    end
  end
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule
